// File: rtl/pin_lock_pkg.sv
// pin_lock_pkg: shared definitions for the PIN lock controller.
//   state_t        : controller states (IDLE, ENTRY, GRANT, PROG, ALARM)
//   DEF_DIGITS     : default PIN length in digits
//   DEF_DIGIT_W    : default bits per digit
//   DEF_PIN        : default stored PIN after reset
package pin_lock_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    GRANT = 3'd2,
    PROG  = 3'd3,
    ALARM = 3'd4
  } state_t;

  localparam int          DEF_DIGITS  = 4;
  localparam int          DEF_DIGIT_W = 4;
  localparam logic [15:0] DEF_PIN     = 16'h1234;

endpackage

// File: rtl/pin_lock_timer.sv
// pin_lock_timer: loadable down-counter with a zero flag.
//   clk        : clock
//   reset_n    : asynchronous active-low reset (count -> 0)
//   load       : load load_value (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one; holds at zero
//   zero       : count is zero
module pin_lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/pin_lock_ctrl.sv
// pin_lock_ctrl: clocked PIN lock controller with timed access pulse,
// consecutive-failure counter, alarm and PIN reprogramming.
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   digit       : keypad digit
//   digit_valid : strobe capturing digit
//   enter       : strobe submitting the attempt
//   prog        : reprogram request, honoured only while access is granted
//   access      : unlock pulse, ACCESS_CYCLES cycles long
//   alarm       : alarm active
//   prog_mode   : collecting a new PIN
//   fail_count  : consecutive failed attempts
// Build option: define PIN_LOCK_CTRL_LOCKOUT_TIMER_EN to make ALARM time out
// after LOCKOUT_CYCLES cycles; otherwise ALARM is left only through reset_n.
module pin_lock_ctrl
  import pin_lock_pkg::*;
#(
  parameter int                          DIGITS         = DEF_DIGITS,
  parameter int                          DIGIT_W        = DEF_DIGIT_W,
  parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_PIN    = (DIGITS*DIGIT_W)'(DEF_PIN),
  parameter int                          MAX_TRIES      = 3,
  parameter int                          ACCESS_CYCLES  = 8,
  parameter int                          LOCKOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DIGIT_W-1:0]             digit,
  input  logic                           digit_valid,
  input  logic                           enter,
  input  logic                           prog,
  output logic                           access,
  output logic                           alarm,
  output logic                           prog_mode,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

  localparam int PIN_W = DIGITS * DIGIT_W;
  localparam int CW    = $clog2(DIGITS + 2);
  localparam int FW    = $clog2(MAX_TRIES + 1);
`ifdef PIN_LOCK_CTRL_LOCKOUT_TIMER_EN
  localparam int TMR_MAX = (ACCESS_CYCLES > LOCKOUT_CYCLES) ? ACCESS_CYCLES : LOCKOUT_CYCLES;
`else
  localparam int TMR_MAX = ACCESS_CYCLES;
`endif
  localparam int TW = $clog2(TMR_MAX + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DIGITS + 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_TRIES);
  // Timers are loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [TW-1:0] ACC_LOAD = TW'(ACCESS_CYCLES - 1);
`ifdef PIN_LOCK_CTRL_LOCKOUT_TIMER_EN
  localparam logic [TW-1:0] LCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
`endif

  if (ACCESS_CYCLES < 1 || LOCKOUT_CYCLES < 1 || MAX_TRIES < 1) begin : g_param_check
    $error("pin_lock_ctrl: cycle counts and MAX_TRIES must be at least 1");
  end

  state_t            state_reg, state_next;
  logic [PIN_W-1:0]  entry_reg, entry_next, entry_upd;
  logic [PIN_W-1:0]  pin_reg, pin_next;
  logic [CW-1:0]     cnt_reg, cnt_next, cnt_upd;
  logic [FW-1:0]     fail_reg, fail_next, fail_inc;
  logic              access_reg, alarm_reg, prog_mode_reg;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]     tmr_value;

  // Same-cycle digit_valid and enter: the comparison sees the digit already
  // shifted in, so compare against these "updated" values.
  always_comb begin
    entry_upd = entry_reg;
    cnt_upd   = cnt_reg;
    if (digit_valid) begin
      entry_upd = (entry_reg << DIGIT_W) | PIN_W'(digit);
      cnt_upd   = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
    end
  end

  assign fail_inc = fail_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    entry_next = entry_reg;
    cnt_next   = cnt_reg;
    fail_next  = fail_reg;
    pin_next   = pin_reg;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_dec    = 1'b0;
    case (state_reg)
      // IDLE keeps entry/count at zero, so it shares ENTRY's handling.
      IDLE, ENTRY: begin
        if (enter) begin
          entry_next = '0;
          cnt_next   = '0;
          if ((cnt_upd == CNT_FULL) && (entry_upd == pin_reg)) begin
            state_next = GRANT;
            fail_next  = '0;
            tmr_load   = 1'b1;
            tmr_value  = ACC_LOAD;
          end else if (fail_inc == FAIL_MAX) begin
            state_next = ALARM;
            fail_next  = fail_inc;
`ifdef PIN_LOCK_CTRL_LOCKOUT_TIMER_EN
            tmr_load   = 1'b1;
            tmr_value  = LCK_LOAD;
`endif
          end else begin
            state_next = IDLE;
            fail_next  = fail_inc;
          end
        end else if (digit_valid) begin
          entry_next = entry_upd;
          cnt_next   = cnt_upd;
          state_next = ENTRY;
        end
      end
      GRANT: begin
        if (prog) begin
          state_next = PROG;
          entry_next = '0;
          cnt_next   = '0;
        end else if (tmr_zero) begin
          state_next = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      PROG: begin
        if (enter) begin
          // A saturated count never equals DIGITS, so overflow is rejected here.
          if (cnt_upd == CNT_FULL) begin
            pin_next = entry_upd;
          end
          entry_next = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (digit_valid) begin
          entry_next = entry_upd;
          cnt_next   = cnt_upd;
        end
      end
      ALARM: begin
`ifdef PIN_LOCK_CTRL_LOCKOUT_TIMER_EN
        if (tmr_zero) begin
          state_next = IDLE;
          fail_next  = '0;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        entry_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      entry_reg     <= '0;
      cnt_reg       <= '0;
      fail_reg      <= '0;
      pin_reg       <= DEFAULT_PIN;
      access_reg    <= 1'b0;
      alarm_reg     <= 1'b0;
      prog_mode_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      entry_reg     <= entry_next;
      cnt_reg       <= cnt_next;
      fail_reg      <= fail_next;
      pin_reg       <= pin_next;
      // Outputs are registered copies of the decoded next state, so they
      // change on the same edge as the state register.
      access_reg    <= (state_next == GRANT);
      alarm_reg     <= (state_next == ALARM);
      prog_mode_reg <= (state_next == PROG);
    end
  end

  // One timer serves both GRANT and ALARM; the states never overlap.
  pin_lock_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  assign access     = access_reg;
  assign alarm      = alarm_reg;
  assign prog_mode  = prog_mode_reg;
  assign fail_count = fail_reg;

endmodule
